// File: rtl/range_step_counter.sv
// Programmable up-counter: steps from startNum toward endNum, clamps onto endNum,
// flags arrival and wraps back to startNum. Next-state value is exported as counter_f.
module range_step_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] startNum,
    input  logic [WIDTH-1:0] endNum,
    input  logic [WIDTH-1:0] step,
    output logic             overflow,
    output logic [WIDTH-1:0] counter,
    output logic [WIDTH-1:0] counter_f
);

    logic [WIDTH:0] sum;
    logic           at_end;

    assign at_end   = (counter == endNum);
    assign overflow = at_end;

    // Extra carry bit makes a wrapped-around sum compare as larger than endNum,
    // so the clamp guarantees endNum is always visited.
    always_comb begin
        sum       = {1'b0, counter} + {1'b0, step};
        counter_f = counter;
        if (en) begin
            if (at_end)
                counter_f = startNum;
            else if (sum > {1'b0, endNum})
                counter_f = endNum;
            else
                counter_f = sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            counter <= startNum;
        else if (clr)
            counter <= startNum;
        else
            counter <= counter_f;
    end

endmodule

// File: tb/tb_range_step_counter.sv
// Directed self-checking bench for range_step_counter.
module tb_range_step_counter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, clr, en;
    logic [W-1:0] startNum, endNum, step;
    logic         overflow;
    logic [W-1:0] counter, counter_f;

    int checks = 0;
    int passed = 0;

    range_step_counter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en),
        .startNum(startNum), .endNum(endNum), .step(step),
        .overflow(overflow), .counter(counter), .counter_f(counter_f)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] exp_c;

        // 1: reset
        rst = 1; clr = 0; en = 0;
        startNum = 32'h0; endNum = 32'hF000_0000; step = 32'h0200_0000;
        tick(); tick();
        chk("rst_counter", counter, 32'h0);
        chk("rst_counter_f", counter_f, 32'h0);
        chk("rst_overflow", {31'b0, overflow}, 32'h0);

        // 2: full run to endNum and wrap
        rst = 0; en = 1;
        #1;
        chk("run_f0", counter_f, 32'h0200_0000);
        for (int i = 1; i <= 120; i++) begin
            tick();
            exp_c = 32'h0200_0000 * i;
            chk("run_counter", counter, exp_c);
            chk("run_overflow", {31'b0, overflow}, (i == 120) ? 32'h1 : 32'h0);
            chk("run_counter_f", counter_f, (i == 120) ? 32'h0 : exp_c + 32'h0200_0000);
        end
        tick();
        chk("wrap_counter", counter, 32'h0);
        chk("wrap_overflow", {31'b0, overflow}, 32'h0);

        // 3: hold then clear
        tick(); tick();
        chk("pre_hold", counter, 32'h0400_0000);
        en = 0;
        #1;
        chk("hold_f", counter_f, 32'h0400_0000);
        tick(); tick();
        chk("hold_counter", counter, 32'h0400_0000);
        chk("hold_f2", counter_f, 32'h0400_0000);
        clr = 1; en = 1;
        tick();
        chk("clr_counter", counter, 32'h0);
        clr = 0;

        // 4: clamp onto a non-multiple endNum
        endNum = 32'd10; step = 32'd4;
        #1;
        chk("clamp_f0", counter_f, 32'd4);
        begin
            logic [W-1:0] seq [5];
            seq = '{32'd4, 32'd8, 32'd10, 32'd0, 32'd4};
            for (int i = 0; i < 5; i++) begin
                tick();
                chk("clamp_counter", counter, seq[i]);
                chk("clamp_overflow", {31'b0, overflow}, (seq[i] == 32'd10) ? 32'h1 : 32'h0);
            end
        end

        // 5: carry-out clamp
        startNum = 32'h9000_0000; endNum = 32'hFFFF_FFFF; step = 32'h8000_0000;
        clr = 1;
        tick();
        clr = 0;
        chk("carry_start", counter, 32'h9000_0000);
        tick();
        chk("carry_clamp", counter, 32'hFFFF_FFFF);
        chk("carry_overflow", {31'b0, overflow}, 32'h1);
        tick();
        chk("carry_wrap", counter, 32'h9000_0000);
        chk("carry_ovf_low", {31'b0, overflow}, 32'h0);

        // 6: reset mid-count dominates clr/en
        startNum = 32'h0; endNum = 32'hF000_0000; step = 32'h0200_0000;
        clr = 1;
        tick();
        clr = 0;
        tick(); tick(); tick();
        chk("mid_counter", counter, 32'h0600_0000);
        startNum = 32'h0100_0000;
        rst = 1; clr = 1; en = 1;
        tick();
        chk("midrst_counter", counter, 32'h0100_0000);
        chk("midrst_overflow", {31'b0, overflow}, 32'h0);
        rst = 0; clr = 0;

        // step=0 holds
        step = 32'h0;
        tick();
        chk("step0_hold", counter, 32'h0100_0000);

        // startNum == endNum: pinned at start with overflow high
        startNum = 32'd5; endNum = 32'd5; step = 32'd3;
        clr = 1;
        tick();
        clr = 0;
        chk("eq_counter", counter, 32'd5);
        chk("eq_overflow", {31'b0, overflow}, 32'h1);
        tick();
        chk("eq_counter2", counter, 32'd5);
        chk("eq_overflow2", {31'b0, overflow}, 32'h1);

        // startNum > endNum: clamp then wrap
        startNum = 32'd20; endNum = 32'd10; step = 32'd1;
        clr = 1;
        tick();
        clr = 0;
        chk("gt_start", counter, 32'd20);
        tick();
        chk("gt_clamp", counter, 32'd10);
        chk("gt_overflow", {31'b0, overflow}, 32'h1);
        tick();
        chk("gt_wrap", counter, 32'd20);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
